branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 199 +++++++++++++++++++
 tb/tb_branch_predictor.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with a 2-bit saturating
//               direction counter per entry, a combinational fetch-side
//               lookup, a one-cycle-latency training port, and saturating
//               resolved-branch / mispredict statistics counters.
//
// Ports
//   clk                 : single clock, all state updates on the rising edge
//   rst_n               : asynchronous active-low reset
//   i_bp_en             : prediction enable (0 forces o_pred_taken=0)
//   i_tbl_flush         : invalidate every entry at the next edge
//   i_if_pc             : fetch PC being looked up
//   o_pred_hit          : valid tag match for i_if_pc
//   o_pred_taken        : predicted redirect
//   o_pred_target       : predicted next PC
//   i_upd_valid         : resolved control transfer present this cycle
//   i_upd_pc            : PC of the resolved instruction
//   i_upd_jump          : 1 = unconditional jump, 0 = conditional branch
//   i_upd_taken         : resolved direction
//   i_upd_target        : resolved target
//   i_upd_pred_taken    : direction predicted at fetch for that instruction
//   i_upd_pred_target   : target predicted at fetch for that instruction
//   o_mispredict        : combinational redirect request
//   o_branch_cnt        : number of resolved updates (saturating)
//   o_mispred_cnt       : number of mispredicts (saturating)
//
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_bp_en,
    input  logic             i_tbl_flush,
    input  logic [XLEN-1:0]  i_if_pc,
    output logic             o_pred_hit,
    output logic             o_pred_taken,
    output logic [XLEN-1:0]  o_pred_target,
    input  logic             i_upd_valid,
    input  logic [XLEN-1:0]  i_upd_pc,
    input  logic             i_upd_jump,
    input  logic             i_upd_taken,
    input  logic [XLEN-1:0]  i_upd_target,
    input  logic             i_upd_pred_taken,
    input  logic [XLEN-1:0]  i_upd_pred_target,
    output logic             o_mispredict,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // 2-bit direction counter encoding
    localparam logic [1:0] c_CTR_SNT = 2'b00;
    localparam logic [1:0] c_CTR_WT  = 2'b10;
    localparam logic [1:0] c_CTR_ST  = 2'b11;

    // ------------------------------------------------------------------
    // Entry storage views (each entry's flops live in g_entry below)
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] w_valid;
    logic [TAG_W-1:0]   w_tag    [ENTRIES];
    logic [XLEN-1:0]    w_target [ENTRIES];
    logic [1:0]         w_ctr    [ENTRIES];

    // ------------------------------------------------------------------
    // Fetch-side lookup (purely combinational from i_if_pc and table state)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_lk_taken;
    logic [XLEN-1:0]  w_lk_seq_pc;

    assign w_lk_idx    = i_if_pc[IDX_W+1:2];
    assign w_lk_tag    = i_if_pc[XLEN-1:IDX_W+2];
    assign w_lk_hit    = w_valid[w_lk_idx] && (w_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken  = i_bp_en && w_lk_hit && w_ctr[w_lk_idx][1];
    assign w_lk_seq_pc = i_if_pc + XLEN'(4);

    assign o_pred_hit    = w_lk_hit;
    assign o_pred_taken  = w_lk_taken;
    assign o_pred_target = w_lk_taken ? w_target[w_lk_idx] : w_lk_seq_pc;

    // ------------------------------------------------------------------
    // Resolution side: mispredict detection and next counter value
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [1:0]       w_up_ctr;
    logic [1:0]       w_up_ctr_next;
    logic             w_mispredict;

    assign w_up_idx = i_upd_pc[IDX_W+1:2];
    assign w_up_tag = i_upd_pc[XLEN-1:IDX_W+2];
    assign w_up_hit = w_valid[w_up_idx] && (w_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr = w_ctr[w_up_idx];

    // A target mismatch only matters when the branch was actually taken;
    // for a not-taken branch the fall-through path is always correct.
    assign w_mispredict = i_upd_valid &&
                          ((i_upd_pred_taken != i_upd_taken) ||
                           (i_upd_taken && (i_upd_pred_target != i_upd_target)));
    assign o_mispredict = w_mispredict;

    always_comb begin
        w_up_ctr_next = w_up_ctr;
        if (i_upd_jump) begin
            // Unconditional transfers are always strongly taken.
            w_up_ctr_next = c_CTR_ST;
        end else if (i_upd_taken) begin
            if (w_up_ctr != c_CTR_ST) begin
                w_up_ctr_next = w_up_ctr + 2'd1;
            end
        end else begin
            if (w_up_ctr != c_CTR_SNT) begin
                w_up_ctr_next = w_up_ctr - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table entries
    // ------------------------------------------------------------------
    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        localparam logic [IDX_W-1:0] c_IDX = IDX_W'(e);

        logic             r_valid;
        logic [TAG_W-1:0] r_tag;
        logic [XLEN-1:0]  r_target;
        logic [1:0]       r_ctr;
        logic             w_sel;

        assign w_sel = i_upd_valid && (w_up_idx == c_IDX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid  <= 1'b0;
                r_tag    <= '0;
                r_target <= '0;
                r_ctr    <= c_CTR_SNT;
            end else if (i_tbl_flush) begin
                // Flush wins over a same-cycle update; tag/target/counter
                // are left as-is since they are ignored while invalid.
                r_valid <= 1'b0;
            end else if (w_sel) begin
                if (w_up_hit) begin
                    r_ctr <= w_up_ctr_next;
                    if (i_upd_taken) begin
                        r_target <= i_upd_target;
                    end
                end else if (i_upd_taken) begin
                    // Miss on a taken transfer: allocate, evicting any alias.
                    r_valid  <= 1'b1;
                    r_tag    <= w_up_tag;
                    r_target <= i_upd_target;
                    r_ctr    <= i_upd_jump ? c_CTR_ST : c_CTR_WT;
                end
            end
        end

        assign w_valid[e]  = r_valid;
        assign w_tag[e]    = r_tag;
        assign w_target[e] = r_target;
        assign w_ctr[e]    = r_ctr;
    end

    // ------------------------------------------------------------------
    // Statistics counters: saturate at all-ones, untouched by flush
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (i_upd_valid && (r_branch_cnt != {CNT_W{1'b1}})) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispredict && (r_mispred_cnt != {CNT_W{1'b1}})) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor. Two instances share
//               stimulus: one with 32-bit statistics counters and one with
//               2-bit counters to exercise saturation. A behavioural table
//               model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bp_en, tbl_flush;
    logic [31:0] if_pc;
    logic        upd_valid, upd_jump, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;

    logic        w_hit, w_taken, w_mis;
    logic [31:0] w_tgt, w_bcnt, w_mcnt;
    logic        w_hit2, w_taken2, w_mis2;
    logic [31:0] w_tgt2;
    logic [1:0]  w_bcnt2, w_mcnt2;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_bp_en(bp_en), .i_tbl_flush(tbl_flush),
        .i_if_pc(if_pc), .o_pred_hit(w_hit), .o_pred_taken(w_taken),
        .o_pred_target(w_tgt), .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
        .i_upd_jump(upd_jump), .i_upd_taken(upd_taken),
        .i_upd_target(upd_target), .i_upd_pred_taken(upd_pred_taken),
        .i_upd_pred_target(upd_pred_target), .o_mispredict(w_mis),
        .o_branch_cnt(w_bcnt), .o_mispred_cnt(w_mcnt)
    );

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .i_bp_en(bp_en), .i_tbl_flush(tbl_flush),
        .i_if_pc(if_pc), .o_pred_hit(w_hit2), .o_pred_taken(w_taken2),
        .o_pred_target(w_tgt2), .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
        .i_upd_jump(upd_jump), .i_upd_taken(upd_taken),
        .i_upd_target(upd_target), .i_upd_pred_taken(upd_pred_taken),
        .i_upd_pred_target(upd_pred_target), .o_mispredict(w_mis2),
        .o_branch_cnt(w_bcnt2), .o_mispred_cnt(w_mcnt2)
    );

    // ---------------- reference model ----------------
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    int unsigned m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    longint unsigned m_bcnt, m_mcnt, m_bcnt2, m_mcnt2;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc >> (IDX_W + 2));
    endfunction

    function automatic bit exp_mispredict();
        return upd_valid && ((upd_pred_taken != upd_taken) ||
                             (upd_taken && (upd_pred_target != upd_target)));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        m_bcnt = 0; m_mcnt = 0; m_bcnt2 = 0; m_mcnt2 = 0;
    endtask

    // Apply one rising edge to the model, using the inputs present at it.
    task automatic m_update();
        int i;
        bit hit;
        i   = idx_of(upd_pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
        if (upd_valid) begin
            if (m_bcnt  < 64'hFFFF_FFFF) m_bcnt++;
            if (m_bcnt2 < 3)             m_bcnt2++;
            if (exp_mispredict()) begin
                if (m_mcnt  < 64'hFFFF_FFFF) m_mcnt++;
                if (m_mcnt2 < 3)             m_mcnt2++;
            end
        end
        if (tbl_flush) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (upd_valid) begin
            if (hit) begin
                if (upd_jump)       m_ctr[i] = 3;
                else if (upd_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                if (upd_taken) m_target[i] = upd_target;
            end else if (upd_taken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(upd_pc);
                m_target[i] = upd_target;
                m_ctr[i]    = upd_jump ? 3 : 2;
            end
        end
    endtask

    // Wait for the falling edge and compare all outputs with the model.
    task automatic sample();
        int          i;
        bit          ehit, etak;
        logic [31:0] etgt;
        @(negedge clk);
        i    = idx_of(if_pc);
        ehit = m_valid[i] && (m_tag[i] == tag_of(if_pc));
        etak = bp_en && ehit && (m_ctr[i] >= 2);
        etgt = etak ? m_target[i] : if_pc + 32'd4;
        check("hit",      w_hit,   ehit);
        check("taken",    w_taken, etak);
        check("target",   w_tgt,   etgt);
        check("mispred",  w_mis,   exp_mispredict());
        check("bcnt",     w_bcnt,  m_bcnt);
        check("mcnt",     w_mcnt,  m_mcnt);
        check("hit_c2",   w_hit2,  ehit);
        check("tgt_c2",   w_tgt2,  etgt);
        check("bcnt_c2",  w_bcnt2, m_bcnt2);
        check("mcnt_c2",  w_mcnt2, m_mcnt2);
        check("taken_c2", w_taken2, etak);
        check("mis_c2",   w_mis2,  exp_mispredict());
    endtask

    task automatic edge_step();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        upd_valid = 0; upd_jump = 0; upd_taken = 0; upd_pred_taken = 0;
        upd_pc = 32'h0; upd_target = 32'h0; upd_pred_target = 32'h0;
        tbl_flush = 0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input bit jmp, input bit tk,
                           input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        upd_valid = 1; upd_pc = pc; upd_jump = jmp; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    // Assert reset mid-cycle; whatever update is pending is discarded.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        check("rst_hit",   w_hit,  1'b0);
        check("rst_taken", w_taken, 1'b0);
        check("rst_tgt",   w_tgt,  if_pc + 32'd4);
        check("rst_bcnt",  w_bcnt, 32'd0);
        check("rst_mcnt",  w_mcnt, 32'd0);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tg;
        case ($urandom_range(0, 3))
            0:       tg = 32'h0;
            1:       tg = 32'h1;
            2:       tg = 32'h4;
            default: tg = 32'h03FF_FFFF;
        endcase
        return (tg << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        rst_n = 1'b0;
        bp_en = 1'b1;
        if_pc = 32'h100;
        idle();
        m_reset();
        #2;
        check("init_hit",  w_hit,  1'b0);
        check("init_tgt",  w_tgt,  32'h104);
        check("init_bcnt", w_bcnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state lookup at 0x100
        sample();
        check("r031_tgt", w_tgt, 32'h104);
        edge_step();

        // Train taken, then decay
        set_upd(32'h100, 0, 1, 32'h80, 0, 32'h104);
        sample();
        check("train_mis", w_mis, 1'b1);
        edge_step();
        idle();
        sample();
        check("train_hit", w_hit, 1'b1);
        check("train_tk",  w_taken, 1'b1);
        check("train_tgt", w_tgt, 32'h80);
        edge_step();
        for (int n = 0; n < 3; n++) begin
            set_upd(32'h100, 0, 0, 32'h0, 1, 32'h80);
            sample();
            edge_step();
            idle();
            sample();
            check("decay_tk",  w_taken, 1'b0);
            check("decay_tgt", w_tgt, 32'h104);
            edge_step();
        end
        // Counter sits at 00: one taken update leaves it not-taken
        set_upd(32'h100, 0, 1, 32'h80, 0, 32'h104);
        sample();
        edge_step();
        idle();
        sample();
        check("sat_lo", w_taken, 1'b0);
        edge_step();
        set_upd(32'h100, 0, 1, 32'h80, 0, 32'h104);
        sample();
        edge_step();
        idle();

        // Aliasing at 0x140 (same index, different tag)
        if_pc = 32'h140;
        sample();
        check("alias_miss", w_hit, 1'b0);
        edge_step();
        set_upd(32'h140, 0, 1, 32'h200, 0, 32'h144);
        sample();
        edge_step();
        idle();
        sample();
        check("alias_hit", w_hit, 1'b1);
        edge_step();
        if_pc = 32'h100;
        sample();
        check("alias_evict", w_hit, 1'b0);
        edge_step();

        // Same-cycle update and lookup sees old state
        if_pc = 32'h140;
        set_upd(32'h140, 0, 0, 32'h0, 1, 32'h200);
        sample();
        check("same_old", w_taken, 1'b1);
        edge_step();
        idle();
        sample();
        check("same_new", w_taken, 1'b0);
        edge_step();

        // Flush overrides a same-cycle update
        set_upd(32'h140, 1, 1, 32'h300, 0, 32'h144);
        tbl_flush = 1;
        sample();
        edge_step();
        idle();
        sample();
        check("flush_miss", w_hit, 1'b0);
        edge_step();

        // Mispredict counting with 2-bit saturating counters
        do_reset();
        for (int n = 1; n <= 4; n++) begin
            set_upd(32'h300, 0, 0, 32'h0, 1, 32'h500);
            sample();
            check("mp_flag", w_mis, 1'b1);
            edge_step();
            idle();
            sample();
            check("mp_cnt2", w_mcnt2, (n > 3) ? 2'd3 : 2'(n));
            edge_step();
        end

        // bp_en=0 suppresses the prediction but not the hit
        if_pc = 32'h100;
        set_upd(32'h100, 0, 1, 32'h80, 0, 32'h104);
        sample();
        edge_step();
        idle();
        bp_en = 0;
        sample();
        check("bpen_hit", w_hit, 1'b1);
        check("bpen_tk",  w_taken, 1'b0);
        edge_step();
        bp_en = 1;

        // PC wrap on the fall-through target
        if_pc = 32'hFFFF_FFFC;
        sample();
        check("wrap_tgt", w_tgt, 32'h0);
        edge_step();

        // Async reset after training, with an update pending
        if_pc = 32'h100;
        sample();
        check("pre_rst_hit", w_hit, 1'b1);
        edge_step();
        set_upd(32'h1C0, 1, 1, 32'h40, 0, 32'h0);
        do_reset();
        if_pc = 32'h1C0;
        sample();
        check("rst_discard", w_hit, 1'b0);
        edge_step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bp_en     = ($urandom_range(0, 9) != 0);
            tbl_flush = ($urandom_range(0, 39) == 0);
            if_pc     = rand_pc();
            upd_valid = ($urandom_range(0, 3) != 0);
            upd_pc    = rand_pc();
            upd_jump  = ($urandom_range(0, 4) == 0);
            upd_taken = upd_jump ? 1'b1 : 1'($urandom_range(0, 1));
            upd_target      = rand_pc();
            upd_pred_taken  = 1'($urandom_range(0, 1));
            upd_pred_target = ($urandom_range(0, 3) == 0) ? rand_pc() : upd_target;
            sample();
            edge_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
